// File: rtl/blink64_pkg.sv
// Shared Blink-64 constants: cell geometry, inverse S-box, shuffle permutations,
// InvMixColumns coefficients and the iterative engine state encoding.
package blink64_pkg;

    localparam int BLOCK_LEN = 64;
    localparam int CELL_W    = 4;
    localparam int NCELLS    = 16;
    localparam int NCOLS     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Cell i lives at bits [4i+3:4i]; column c holds cells 4c..4c+3.
    localparam logic [CELL_W-1:0] INV_SBOX [NCELLS] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    // Forward shuffle: out cell i takes in cell SHUFFLE[i].
    localparam int SHUFFLE [NCELLS] = '{
        0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8
    };

    function automatic int inv_shuffle_at(input int k);
        int r;
        r = 0;
        for (int i = 0; i < NCELLS; i++) begin
            if (SHUFFLE[i] == k) r = i;
        end
        return r;
    endfunction

    // Derived from SHUFFLE so the two tables can never disagree.
    localparam int INV_SHUFFLE [NCELLS] = '{
        inv_shuffle_at(0),  inv_shuffle_at(1),  inv_shuffle_at(2),  inv_shuffle_at(3),
        inv_shuffle_at(4),  inv_shuffle_at(5),  inv_shuffle_at(6),  inv_shuffle_at(7),
        inv_shuffle_at(8),  inv_shuffle_at(9),  inv_shuffle_at(10), inv_shuffle_at(11),
        inv_shuffle_at(12), inv_shuffle_at(13), inv_shuffle_at(14), inv_shuffle_at(15)
    };

    // The mixing matrix is involutory, so the inverse uses the same coefficients.
    localparam logic [CELL_W-1:0] INV_MIX [NCOLS][NCOLS] = '{
        '{4'h0, 4'h1, 4'h1, 4'h1},
        '{4'h1, 4'h0, 4'h1, 4'h1},
        '{4'h1, 4'h1, 4'h0, 4'h1},
        '{4'h1, 4'h1, 4'h1, 4'h0}
    };

    // GF(2^4) multiply, reduction polynomial x^4 + x + 1.
    function automatic logic [CELL_W-1:0] gf16_mul(input logic [CELL_W-1:0] a,
                                                   input logic [CELL_W-1:0] b);
        logic [CELL_W-1:0] p;
        logic [CELL_W-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < CELL_W; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[CELL_W-2:0], 1'b0} ^ (aa[CELL_W-1] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

endpackage

// File: rtl/r_inv.sv
// One combinational Blink-64 inverse round:
// outdata = InvSubCells(InvMixColumns(InvShuffleCells(indata) ^ key)).
module r_inv
    import blink64_pkg::*;
(
    input  logic [BLOCK_LEN-1:0] indata,
    input  logic [BLOCK_LEN-1:0] key,
    output logic [BLOCK_LEN-1:0] outdata
);

    logic [BLOCK_LEN-1:0] unshuf;
    logic [BLOCK_LEN-1:0] keyed;
    logic [BLOCK_LEN-1:0] unmix;

    always_comb begin
        unshuf = '0;
        for (int i = 0; i < NCELLS; i++) begin
            unshuf[i*CELL_W +: CELL_W] = indata[INV_SHUFFLE[i]*CELL_W +: CELL_W];
        end
    end

    assign keyed = unshuf ^ key;

    always_comb begin : mix_p
        logic [CELL_W-1:0] acc;
        unmix = '0;
        acc   = '0;
        for (int c = 0; c < NCOLS; c++) begin
            for (int r = 0; r < NCOLS; r++) begin
                acc = '0;
                for (int j = 0; j < NCOLS; j++) begin
                    acc = acc ^ gf16_mul(INV_MIX[r][j], keyed[(NCOLS*c+j)*CELL_W +: CELL_W]);
                end
                unmix[(NCOLS*c+r)*CELL_W +: CELL_W] = acc;
            end
        end
    end

    always_comb begin
        outdata = '0;
        for (int i = 0; i < NCELLS; i++) begin
            outdata[i*CELL_W +: CELL_W] = INV_SBOX[unmix[i*CELL_W +: CELL_W]];
        end
    end

endmodule

// File: rtl/r_inv_iter.sv
// Iterative Blink-64 decryption engine: one inverse round per clock, tweakeys
// fetched by descending index, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high, rk_idx parked at ROUNDS-1
// RUN   | applying round ctr with rk = table[ctr]; leaves after round 0
// DONE  | result held on out_data with out_valid high until out_ready
module r_inv_iter #(
    parameter int BLOCK_LEN = 64,
    parameter int ROUNDS    = 16,
    parameter int RIDX_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLOCK_LEN-1:0] in_data,
    output logic [RIDX_W-1:0]    rk_idx,
    input  logic [BLOCK_LEN-1:0] rk,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLOCK_LEN-1:0] out_data,
    output logic                 busy
);

    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(ROUNDS - 1);

    blink64_pkg::state_t  fsm_q, fsm_d;
    logic [RIDX_W-1:0]    ctr_q, ctr_d;
    logic [BLOCK_LEN-1:0] blk_q, blk_d;
    logic [BLOCK_LEN-1:0] res_q, res_d;
    logic [BLOCK_LEN-1:0] round_out;

    r_inv u_round (
        .indata  (blk_q),
        .key     (rk),
        .outdata (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= blink64_pkg::IDLE;
            ctr_q <= LAST_IDX;
            blk_q <= '0;
            res_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            ctr_q <= ctr_d;
            blk_q <= blk_d;
            res_q <= res_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        ctr_d = ctr_q;
        blk_d = blk_q;
        res_d = res_q;
        case (fsm_q)
            blink64_pkg::IDLE: begin
                if (in_valid) begin
                    blk_d = in_data;
                    ctr_d = LAST_IDX;
                    fsm_d = blink64_pkg::RUN;
                end
            end
            blink64_pkg::RUN: begin
                blk_d = round_out;
                if (ctr_q == '0) begin
                    res_d = round_out;
                    fsm_d = blink64_pkg::DONE;
                end else begin
                    ctr_d = ctr_q - RIDX_W'(1);
                end
            end
            blink64_pkg::DONE: begin
                if (out_ready) begin
                    ctr_d = LAST_IDX;
                    fsm_d = blink64_pkg::IDLE;
                end
            end
            default: begin
                fsm_d = blink64_pkg::IDLE;
                ctr_d = LAST_IDX;
            end
        endcase
    end

    // Outputs depend only on registered state, so rk_idx is glitch-free per cycle.
    assign in_ready  = (fsm_q == blink64_pkg::IDLE);
    assign out_valid = (fsm_q == blink64_pkg::DONE);
    assign busy      = (fsm_q == blink64_pkg::RUN) || (fsm_q == blink64_pkg::DONE);
    assign rk_idx    = (fsm_q == blink64_pkg::RUN) ? ctr_q : LAST_IDX;
    assign out_data  = res_q;

endmodule

// File: tb/tb_r_inv_iter.sv
// Bench for r_inv_iter: forward-cipher reference model, round-trip sweep of the
// single-round block, then directed handshake/backpressure/reset/streaming steps.
module tb_r_inv_iter;

    localparam int ROUNDS = 16;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };
    localparam int PERM [16] = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] in_data, rk, out_data;
    logic [7:0]  rk_idx;
    logic [63:0] rk_tbl [0:255];
    logic [63:0] ri_in, ri_key, ri_out;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rk = rk_tbl[rk_idx];

    r_inv_iter #(.BLOCK_LEN(64), .ROUNDS(ROUNDS), .RIDX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    r_inv u_ri (
        .indata  (ri_in),
        .key     (ri_key),
        .outdata (ri_out)
    );

    // Forward round R(x,tk) = Shuffle(Mix(Sub(x)) ^ tk); Mix replaces each cell
    // by the xor of the other three cells of its column.
    function automatic logic [63:0] fwd_round(input logic [63:0] x, input logic [63:0] tk);
        logic [3:0]  c [16];
        logic [63:0] v, y;
        for (int i = 0; i < 16; i++) c[i] = SBOX[x[4*i +: 4]];
        for (int col = 0; col < 4; col++) begin
            for (int r = 0; r < 4; r++) begin
                v[4*(4*col+r) +: 4] = c[4*col] ^ c[4*col+1] ^ c[4*col+2] ^ c[4*col+3] ^ c[4*col+r];
            end
        end
        v = v ^ tk;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = v[4*PERM[i] +: 4];
        return y;
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] pt);
        logic [63:0] x;
        x = pt;
        for (int r = 0; r < ROUNDS; r++) x = fwd_round(x, rk_tbl[r]);
        return x;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [63:0] ct);
        check("accept_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = ct;
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
    endtask

    task automatic wait_result(input logic [63:0] exp, input int exp_wait, input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, out_valid, 1'b1);
        check({tag, "_latency"}, n, exp_wait);
        check(tag, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_release"}, in_ready, 1'b1);
    endtask

    logic [63:0] x, tk, pt, ct, pt2, ct2;
    logic [63:0] b_pt [3];
    logic [63:0] b_ct [3];
    logic [63:0] od;
    logic        took_in, took_out;
    int          acc [3];
    int          na, nd;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        ri_in = '0; ri_key = '0;
        for (int i = 0; i < 256; i++) rk_tbl[i] = '0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_rk_idx", rk_idx, 15);
        rst = 1'b0;
        tick();

        // Single inverse round undoes the forward round.
        for (int n = 0; n < 10000; n++) begin
            x  = {$urandom, $urandom};
            tk = {$urandom, $urandom};
            if (n == 0) x = '0;
            if (n == 1) x = '1;
            if (n == 2) tk = '0;
            if (n == 3) begin x = '0; tk = '0; end
            if (n == 4) begin x = '1; tk = '1; end
            ri_key = tk;
            ri_in  = fwd_round(x, tk);
            #1;
            check("round_trip", ri_out, x);
        end

        // Full decrypt with key order, latency and backpressure.
        for (int i = 0; i < ROUNDS; i++) rk_tbl[i] = {$urandom, $urandom};
        pt = {$urandom, $urandom};
        ct = encrypt(pt);
        start_block(ct);
        for (int k = 0; k < ROUNDS; k++) begin
            check("rk_idx_seq", rk_idx, ROUNDS - 1 - k);
            check("run_busy", busy, 1'b1);
            check("run_in_ready", in_ready, 1'b0);
            check("run_no_valid", out_valid, 1'b0);
            tick();
        end
        check("dec_valid", out_valid, 1'b1);
        check("dec_data", out_data, pt);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, pt);
            check("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_ready", in_ready, 1'b1);
        check("bp_release_busy", busy, 1'b0);

        // in_valid and stray out_ready during RUN are ignored.
        pt2 = {$urandom, $urandom};
        ct2 = encrypt(pt2);
        start_block(ct2);
        tick(); tick(); tick();
        in_valid  = 1'b1;
        in_data   = {$urandom, $urandom};
        out_ready = 1'b1;
        tick(); tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("ignore_rk_idx", rk_idx, 10);
        wait_result(pt2, 11, "ignore_data");

        // Reset in the middle of a block.
        pt = {$urandom, $urandom};
        ct = encrypt(pt);
        start_block(ct);
        for (int k = 0; k < 8; k++) tick();
        check("pre_rst_ctr", rk_idx, 7);
        rst = 1'b1;
        tick();
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_data", out_data, 64'h0);
        check("midrst_rk_idx", rk_idx, 15);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < ROUNDS; i++) rk_tbl[i] = {$urandom, $urandom};
        pt = {$urandom, $urandom};
        ct = encrypt(pt);
        start_block(ct);
        wait_result(pt, 16, "post_rst_data");

        // Back-to-back stream with in_valid held and out_ready tied high.
        for (int i = 0; i < 3; i++) begin
            b_pt[i] = {$urandom, $urandom};
            b_ct[i] = encrypt(b_pt[i]);
            acc[i]  = 0;
        end
        na = 0; nd = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = b_ct[0];
        for (int cyc = 0; cyc < 200 && nd < 3; cyc++) begin
            took_in  = in_valid && in_ready;
            took_out = out_valid && out_ready;
            od       = out_data;
            tick();
            if (took_in && na < 3) begin
                acc[na] = cyc;
                na++;
                if (na < 3) in_data = b_ct[na];
                else in_valid = 1'b0;
            end
            if (took_out && nd < 3) begin
                check("b2b_data", od, b_pt[nd]);
                nd++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", nd, 3);
        check("b2b_gap1", acc[1] - acc[0], ROUNDS + 2);
        check("b2b_gap2", acc[2] - acc[1], ROUNDS + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/r_inv_iter.md
Name: r_inv_iter

Overview:
Iterative Blink-64 inverse-round engine: the decryption direction of the forward round function R. It accepts one 64-bit block over a valid/ready handshake and applies ROUNDS inverse rounds, one per clock, using round tweakeys fetched by index from the key-schedule side. It returns the result over a valid/ready handshake. It sits between the decryption datapath front end and the output buffer, sharing round-tweakey storage with the encryption core.

Parameters:
BLOCK_LEN, 64, block and tweakey width in bits; only 64 is supported
ROUNDS, 16, number of inverse rounds per block; must be 2..255
RIDX_W, 8, width of the round-tweakey index; must satisfy 2^RIDX_W >= ROUNDS

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  ciphertext block offered
in_ready  output  1  engine can accept a block
in_data  input  BLOCK_LEN  ciphertext block
rk_idx  output  RIDX_W  index of the round tweakey needed this cycle
rk  input  BLOCK_LEN  round tweakey for rk_idx, combinational from the key store, same cycle
out_valid  output  1  result block valid
out_ready  input  1  consumer accepts the result
out_data  output  BLOCK_LEN  decrypted block
busy  output  1  high in RUN or DONE

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, round counter=ROUNDS-1, state register=0.
- Inverse round r_inv(y, tk) = InvSubCells(InvMixColumns(InvShuffleCells(y) xor tk)).
  - Normative property: r_inv(R(x, tk), tk) = x for all x and tk.
- FSM states:
  - IDLE: in_ready=1, rk_idx=ROUNDS-1. A handshake (in_valid && in_ready) loads in_data into the state register, sets ctr=ROUNDS-1 and moves to RUN.
  - RUN: in_ready=0 and rk_idx=ctr. Each cycle, state <= r_inv(state, rk).
    - If ctr!=0, then ctr <= ctr-1.
    - If ctr==0, the final round result goes to both out_data and the state register, and the FSM moves to DONE.
  - DONE: out_valid=1 and out_data is held stable. When out_ready=1, out_valid drops on the next edge, the FSM moves to IDLE and ctr reloads to ROUNDS-1.
- Key order: round tweakeys are consumed in descending index order, ROUNDS-1 down to 0. rk must be stable while rk_idx is stable.
- Latency: handshake at edge t gives out_valid=1 after edge t+ROUNDS.
  - With out_ready tied high, in_ready rises after edge t+ROUNDS+1.
  - Throughput is 1 block per ROUNDS+2 cycles.
- in_ready=0 in RUN and DONE, so in_valid is ignored there. The upstream must hold in_data until the handshake.
- out_ready asserted while out_valid=0 has no effect.
- rst mid-RUN or mid-DONE: the block is aborted with no output, and all registers return to their reset values on that edge.
- rk_idx is combinational from the FSM and ctr and never glitches across states within a cycle.
- Arithmetic: ctr is RIDX_W bits, decrements only in RUN and never wraps.

Decomposition:
- Shared package blink64_pkg holds:
  - constants BLOCK_LEN=64, CELL_W=4, NCELLS=16
  - inverse S-box table
  - forward and inverse shuffle permutations
  - InvMixColumns coefficients
  - state enum {IDLE, RUN, DONE}
- One combinational sub-module, r_inv (indata, key, outdata), implements a single inverse round. It is instantiated once inside r_inv_iter, which owns the FSM, counter and registers.

Test Plan:
- Round trip: random x and tk, drive R(x,tk) into one r_inv instance -> output equals x, over 10^4 vectors including x=0, x=all-ones and tk=0.
- Full decrypt with ROUNDS=16: after reset, in_data=ciphertext from the golden model and rk=table[rk_idx] -> rk_idx sequence 15,14,...,0 on consecutive cycles, out_valid at edge t+16, out_data = golden plaintext.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data and out_valid stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 one cycle later.
- Ignored input: pulse in_valid with different data during RUN -> no state change, and the result matches the first block only.
- Reset mid-operation: assert rst at ctr=7 -> next cycle out_valid=0, in_ready=1, out_data=0, rk_idx=15. A fresh block then decrypts correctly.
- Back-to-back: 3 blocks with in_valid held high and out_ready=1 -> 3 correct results, accept edges spaced exactly ROUNDS+2=18 cycles apart.
